vga_sync_receiver: RTL and testbench

Receive side of the VGA timing interface. Samples an incoming hsync/vsync/write-enable stream, as produced by a horizontal/vertical vga_timer pair, and recovers the active-area pixel coordinates. Checks every line and frame against the configured timing and reports lock and error status. Sits in front of capture, overlay or loopback-check logic that needs per-pixel x/y from an external or looped-back VGA stream.

---
 rtl/vga_sync_receiver.sv | 189 ++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers active-area x/y from an hsync/vsync/wen stream
// and tracks timing lock against the configured horizontal/vertical timing.
package vga_timing_pkg;
  typedef struct packed {
    int unsigned A_FRONT_PORCH;
    int unsigned A_SYNC;
    int unsigned A_BACK_PORCH;
    int unsigned A_VISIBLE;
    int unsigned A_TOTAL;
  } vga_timing_cfg_t;

  localparam vga_timing_cfg_t VGA_640X480_H_TIMING = '{
    A_FRONT_PORCH: 16, A_SYNC: 96, A_BACK_PORCH: 48, A_VISIBLE: 640, A_TOTAL: 800};
  localparam vga_timing_cfg_t VGA_640X480_V_TIMING = '{
    A_FRONT_PORCH: 10, A_SYNC: 2, A_BACK_PORCH: 33, A_VISIBLE: 480, A_TOTAL: 525};
endpackage

module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter vga_timing_cfg_t H_CFG       = VGA_640X480_H_TIMING,
  parameter vga_timing_cfg_t V_CFG       = VGA_640X480_V_TIMING,
  parameter int unsigned     LOCK_FRAMES = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rstn,
  input  logic                                i_en,
  input  logic                                i_hsync,
  input  logic                                i_vsync,
  input  logic                                i_wen,
  output logic [$clog2(H_CFG.A_VISIBLE)-1:0]  o_x,
  output logic [$clog2(V_CFG.A_VISIBLE)-1:0]  o_y,
  output logic                                o_valid,
  output logic                                o_locked,
  output logic                                o_frame_start,
  output logic                                o_err
);

  localparam int HW = $clog2(H_CFG.A_TOTAL);
  localparam int VW = $clog2(V_CFG.A_TOTAL);
  localparam int XW = $clog2(H_CFG.A_VISIBLE);
  localparam int YW = $clog2(V_CFG.A_VISIBLE);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_CFG.A_TOTAL - 1);
  localparam logic [HW-1:0] H_START = HW'(H_CFG.A_SYNC + H_CFG.A_BACK_PORCH);
  localparam logic [HW-1:0] H_END   = HW'(H_CFG.A_SYNC + H_CFG.A_BACK_PORCH + H_CFG.A_VISIBLE - 1);
  localparam logic [HW:0]   H_SYNCW = (HW+1)'(H_CFG.A_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_CFG.A_TOTAL - 1);
  localparam logic [VW-1:0] V_START = VW'(V_CFG.A_SYNC + V_CFG.A_BACK_PORCH);
  localparam logic [VW-1:0] V_END   = VW'(V_CFG.A_SYNC + V_CFG.A_BACK_PORCH + V_CFG.A_VISIBLE - 1);
  localparam logic [VW:0]   V_SYNCW = (VW+1)'(V_CFG.A_SYNC);
  localparam logic [GW-1:0] G_LAST  = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  logic          hs_s, hs_p, vs_s, vs_p, wen_s;
  logic [HW-1:0] h_cnt, h_cur;
  logic [VW-1:0] v_cnt, v_cur;
  logic [HW:0]   hs_w;
  logic [VW:0]   vs_lines;
  logic          v_pend;
  logic          hfall, hrise, vfall, vrise, frame_edge, win, fail;
  state_t        state, state_n;
  logic [GW-1:0] good, good_n;
  logic [XW-1:0] x_n;
  logic [YW-1:0] y_n;
  logic          valid_n, fs_n, err_n;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hs_s  <= 1'b1;
      hs_p  <= 1'b1;
      vs_s  <= 1'b1;
      vs_p  <= 1'b1;
      wen_s <= 1'b0;
    end else if (i_en) begin
      hs_p  <= hs_s;
      hs_s  <= i_hsync;
      vs_p  <= vs_s;
      vs_s  <= i_vsync;
      wen_s <= i_wen;
    end
  end

  // Counts for the current stage-1 sample; registers hold the previous sample's view.
  always_comb begin
    hfall      = hs_p & ~hs_s;
    hrise      = ~hs_p & hs_s;
    vfall      = vs_p & ~vs_s;
    vrise      = ~vs_p & vs_s;
    frame_edge = hfall & v_pend;
    h_cur      = hfall ? '0 : ((h_cnt == '1) ? h_cnt : h_cnt + 1'b1);
    if (frame_edge)
      v_cur = '0;
    else if (hfall && v_cnt != '1)
      v_cur = v_cnt + 1'b1;
    else
      v_cur = v_cnt;
    win  = (h_cur >= H_START) && (h_cur <= H_END) && (v_cur >= V_START) && (v_cur <= V_END);
    fail = (hfall && h_cnt != H_LAST) || (hrise && hs_w != H_SYNCW) ||
           (frame_edge && v_cnt != V_LAST) || (vrise && vs_lines != V_SYNCW) ||
           (wen_s != win);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      hs_w     <= '0;
      vs_lines <= '0;
      v_pend   <= 1'b0;
    end else if (i_en) begin
      h_cnt  <= h_cur;
      v_cnt  <= v_cur;
      v_pend <= vfall | (v_pend & ~frame_edge);
      if (hfall)
        hs_w <= (HW+1)'(1);
      else if (!hs_s && hs_w != '1)
        hs_w <= hs_w + 1'b1;
      if (vfall)
        vs_lines <= hfall ? (VW+1)'(1) : '0;
      else if (!vs_s && hfall && vs_lines != '1)
        vs_lines <= vs_lines + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= SEARCH;
      good  <= '0;
    end else begin
      state <= state_n;
      good  <= good_n;
    end
  end

  // A failure outranks a simultaneous frame edge, so a bad frame never counts toward lock.
  always_comb begin
    state_n = state;
    good_n  = good;
    if (i_en) begin
      case (state)
        SEARCH: if (frame_edge) begin
          state_n = CHECK;
          good_n  = '0;
        end
        CHECK: if (fail) begin
          state_n = SEARCH;
        end else if (frame_edge) begin
          good_n = good + 1'b1;
          if (good == G_LAST) state_n = LOCKED;
        end
        LOCKED: if (fail) state_n = SEARCH;
        default: state_n = SEARCH;
      endcase
    end
  end

  always_comb begin
    err_n   = i_en && (state == LOCKED) && fail;
    valid_n = (state_n == LOCKED) && wen_s && win;
    x_n     = win ? XW'(h_cur - H_START) : '0;
    y_n     = win ? YW'(v_cur - V_START) : '0;
    fs_n    = valid_n && (x_n == '0) && (y_n == '0);
  end

  assign o_locked = (state == LOCKED);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_x           <= '0;
      o_y           <= '0;
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end else if (i_en) begin
      o_x           <= x_n;
      o_y           <= y_n;
      o_valid       <= valid_n;
      o_frame_start <= fs_n;
      o_err         <= err_n;
    end else begin
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized-enable bench for vga_sync_receiver on a scaled-down timing, with
// injected timing faults and a sample-history reference model.
module tb_vga_sync_receiver;
  import vga_timing_pkg::*;

  localparam int HFP = 2, HS = 3, HB = 2, HV = 8, HT = 15;
  localparam int VFP = 1, VS = 2, VB = 1, VV = 4, VT = 8;
  localparam int LF = 2;
  localparam int FRAME = HT * VT;
  localparam int HMAX = (1 << $clog2(HT)) - 1;
  localparam int VMAX = (1 << $clog2(VT)) - 1;
  localparam int XW = $clog2(HV);
  localparam int YW = $clog2(VV);
  localparam vga_timing_cfg_t H_T = '{A_FRONT_PORCH: HFP, A_SYNC: HS, A_BACK_PORCH: HB, A_VISIBLE: HV, A_TOTAL: HT};
  localparam vga_timing_cfg_t V_T = '{A_FRONT_PORCH: VFP, A_SYNC: VS, A_BACK_PORCH: VB, A_VISIBLE: VV, A_TOTAL: VT};

  logic          clk, rstn, en, hsync, vsync, wen;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic          o_valid, o_locked, o_frame_start, o_err;

  vga_sync_receiver #(.H_CFG(H_T), .V_CFG(V_T), .LOCK_FRAMES(LF)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_hsync(hsync), .i_vsync(vsync), .i_wen(wen),
    .o_x(o_x), .o_y(o_y), .o_valid(o_valid), .o_locked(o_locked),
    .o_frame_start(o_frame_start), .o_err(o_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared = 0, n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream generator: line = FP, sync, BP, visible; frame likewise in lines.
  int gen_h = 0, gen_v = 0, cur_len = HT, cur_hsw = HS, cur_vsl = VS;
  bit cur_early = 0, f_short = 0, f_narrow = 0, f_vlong = 0, f_early = 0;

  task automatic gen_sample(output bit hs, output bit vs, output bit w);
    bit hvis, vvis;
    hs   = !(gen_h >= HFP && gen_h < HFP + cur_hsw);
    vs   = !(gen_v >= VFP && gen_v < VFP + cur_vsl);
    hvis = gen_h >= HFP + HS + HB && gen_h < HT;
    vvis = gen_v >= VFP + VS + VB;
    w    = (hvis && vvis) || (cur_early && vvis && gen_h == HFP + HS + HB - 1);
    gen_h++;
    if (gen_h >= cur_len) begin
      gen_h = 0;
      gen_v = (gen_v + 1) % VT;
      cur_len = HT; cur_hsw = HS; cur_early = 0;
      if (gen_v == 0) begin cur_vsl = f_vlong ? VS + 1 : VS; f_vlong = 0; end
      if (f_short && gen_v == VFP + VS) begin cur_len = HT - 1; f_short = 0; end
      if (f_narrow) begin cur_hsw = HS - 1; f_narrow = 0; end
      if (f_early && gen_v >= VFP + VS + VB) begin cur_early = 1; f_early = 0; end
    end
  endtask

  // Reference model: counts are derived from event indices in the sample history.
  int m_idx, m_last_hf, m_hf_total, m_hf_at_edge, m_vlow_hf, m_vlow_base, m_clean;
  bit m_pend, m_search, m_locked;
  bit m_cur_hs, m_cur_vs, m_cur_w, m_last_hs, m_last_vs;
  bit drv_hs, drv_vs, drv_w, en_prev;
  int e_x, e_y;
  bit e_valid, e_locked, e_fs, e_err;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_last_hf = -1; m_hf_total = 0; m_hf_at_edge = 0;
    m_vlow_hf = 0; m_vlow_base = 0; m_clean = 0;
    m_pend = 0; m_search = 1; m_locked = 0;
    m_cur_hs = 1; m_cur_vs = 1; m_cur_w = 0; m_last_hs = 1; m_last_vs = 1;
    e_x = 0; e_y = 0; e_valid = 0; e_locked = 0; e_fs = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit hfall, hrise, vfall, vrise, fedge, fail, inwin;
    int h_now, v_now;
    hfall = m_last_hs && !m_cur_hs;
    hrise = !m_last_hs && m_cur_hs;
    vfall = m_last_vs && !m_cur_vs;
    vrise = !m_last_vs && m_cur_vs;
    fedge = hfall && m_pend;
    fail = 0;
    if (hfall && imin(m_idx - 1 - m_last_hf, HMAX) != HT - 1) fail = 1;
    if (hrise && (m_idx - m_last_hf) != HS) fail = 1;
    if (fedge && imin(m_hf_total - m_hf_at_edge, VMAX) != VT - 1) fail = 1;
    if (vrise && (m_vlow_hf - m_vlow_base) != VS) fail = 1;
    if (vfall) m_vlow_base = m_vlow_hf;
    if (hfall) begin
      if (!m_cur_vs) m_vlow_hf++;
      m_hf_total++;
      m_last_hf = m_idx;
      if (fedge) m_hf_at_edge = m_hf_total;
    end
    m_pend = vfall ? 1'b1 : (fedge ? 1'b0 : m_pend);
    h_now = imin(m_idx - m_last_hf, HMAX);
    v_now = imin(m_hf_total - m_hf_at_edge, VMAX);
    inwin = h_now >= HS + HB && h_now < HS + HB + HV && v_now >= VS + VB && v_now < VS + VB + VV;
    if (m_cur_w != inwin) fail = 1;
    e_err = 0;
    if (m_search) begin
      if (fedge) begin m_search = 0; m_clean = 0; end
    end else if (fail) begin
      e_err = m_locked; m_search = 1; m_locked = 0;
    end else if (fedge && !m_locked) begin
      m_clean++;
      if (m_clean == LF) m_locked = 1;
    end
    e_locked = m_locked;
    e_valid  = m_locked && m_cur_w && inwin;
    e_x = inwin ? h_now - (HS + HB) : 0;
    e_y = inwin ? v_now - (VS + VB) : 0;
    e_fs = e_valid && e_x == 0 && e_y == 0;
    m_idx++;
  endtask

  int err_seen = 0, valid_cnt = 0;
  bit stats_armed = 0;

  task automatic cycle_check();
    if (en_prev) begin
      model_step();
      m_last_hs = m_cur_hs; m_last_vs = m_cur_vs;
      m_cur_hs = drv_hs; m_cur_vs = drv_vs; m_cur_w = drv_w;
    end else begin
      e_fs = 0; e_err = 0;
    end
    checkOutput("x", 32'(o_x), e_x);
    checkOutput("y", 32'(o_y), e_y);
    checkOutput("valid", 32'(o_valid), 32'(e_valid));
    checkOutput("locked", 32'(o_locked), 32'(e_locked));
    checkOutput("frame_start", 32'(o_frame_start), 32'(e_fs));
    checkOutput("err", 32'(o_err), 32'(e_err));
    if (en_prev) begin
      if (o_err) begin
        err_seen++;
        checkOutput("locked_drop_on_err", 32'(o_locked), 0);
      end
      if (!o_locked) stats_armed = 0;
      if (o_frame_start) begin
        if (stats_armed) checkOutput("valid_per_frame", valid_cnt, HV * VV);
        stats_armed = 1;
        valid_cnt = 0;
      end
      if (o_valid) valid_cnt++;
    end
  endtask

  task automatic drive_next(input bit en_v);
    en = en_v;
    if (en_v) begin
      gen_sample(drv_hs, drv_vs, drv_w);
      hsync = drv_hs; vsync = drv_vs; wen = drv_w;
    end else begin
      hsync = 1'($urandom_range(1));
      vsync = 1'($urandom_range(1));
      wen   = 1'($urandom_range(1));
    end
    en_prev = en_v;
  endtask

  task automatic applyStimulus(input int n_enabled, input int en_pct);
    int cnt = 0;
    bit en_v;
    while (cnt < n_enabled) begin
      @(negedge clk);
      cycle_check();
      en_v = ($urandom_range(99) < en_pct);
      drive_next(en_v);
      if (en_v) cnt++;
    end
  endtask

  task automatic fault_phase(input string name);
    err_seen = 0;
    applyStimulus(2 * FRAME, 80);
    checkOutput({"err_count_", name}, err_seen, 1);
    applyStimulus(4 * FRAME, 80);
    checkOutput({"relock_", name}, 32'(o_locked), 1);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; hsync = 1'b1; vsync = 1'b1; wen = 1'b0;
    en_prev = 0;
    model_reset();
    repeat (3) begin @(negedge clk); cycle_check(); end
    @(negedge clk);
    cycle_check();
    rstn = 1'b1;
    drive_next(1'b1);

    applyStimulus(5 * FRAME, 100);
    checkOutput("locked_clean", 32'(o_locked), 1);
    applyStimulus(3 * FRAME, 60);
    checkOutput("locked_random_en", 32'(o_locked), 1);

    f_short = 1;  fault_phase("short_line");
    f_narrow = 1; fault_phase("narrow_hsync");
    f_vlong = 1;  fault_phase("long_vsync");
    f_early = 1;  fault_phase("early_wen");

    applyStimulus(FRAME / 2 + 7, 80);
    checkOutput("locked_before_reset", 32'(o_locked), 1);
    @(negedge clk);
    cycle_check();
    drive_next(1'b0);
    #2 rstn = 1'b0;
    #1;
    checkOutput("async_rst_x", 32'(o_x), 0);
    checkOutput("async_rst_y", 32'(o_y), 0);
    checkOutput("async_rst_valid", 32'(o_valid), 0);
    checkOutput("async_rst_locked", 32'(o_locked), 0);
    model_reset();
    en_prev = 0;
    @(negedge clk);
    cycle_check();
    rstn = 1'b1;
    drive_next(1'b1);
    applyStimulus(FRAME + 20, 80);
    checkOutput("no_early_relock", 32'(o_locked), 0);
    applyStimulus(3 * FRAME, 80);
    checkOutput("relock_after_reset", 32'(o_locked), 1);

    @(negedge clk);
    cycle_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
